ipsxe_fft_rst_seq: RTL and testbench

IPSXE_FFT_RST_SEQ -- requirements
Module: ipsxe_fft_rst_seq

---
 rtl/ipsxe_fft_rst_pkg.sv | 18 +
 rtl/ipsxe_fft_rst_sync_cell.sv | 26 ++
 rtl/ipsxe_fft_rst_seq.sv | 121 ++++++++++++
 tb/tb_ipsxe_fft_rst_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ipsxe_fft_rst_pkg.sv
// Shared state encoding and counter sizing for the sequenced reset generator.
package ipsxe_fft_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_DONE    = 2'd3
    } rstState_e;

    // The counter must hold the largest of the hold and gap limits without wrapping.
    function automatic int cntWidth(input int holdCyc, input int gapCyc);
        int maxCyc;
        maxCyc = (holdCyc > gapCyc) ? holdCyc : gapCyc;
        return $clog2(maxCyc + 1);
    endfunction

endpackage

// File: rtl/ipsxe_fft_rst_sync_cell.sv
// One reset-request synchroniser: shifts in ones, cleared whenever its source is sampled low.
module ipsxe_fft_rst_sync_cell
    import ipsxe_fft_rst_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_arstn,
    output logic o_sync
);

    logic [STAGES-1:0] chain_q;

    // A single low sample wipes the whole chain so the request can never be missed downstream.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_arstn) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    assign o_sync = chain_q[STAGES-1];

endmodule

// File: rtl/ipsxe_fft_rst_seq.sv
// Sequenced reset release: holds all outputs in reset until the requests stay quiet, then frees them in order.
// Optional release-event counter output o_rst_cnt is enabled with IPSXE_FFT_RST_SEQ_CNT_EN.
module ipsxe_fft_rst_seq
    import ipsxe_fft_rst_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 16,
    parameter int N_OUT       = 4,
    parameter int GAP_CYC     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_arstn_src,
    output logic [N_OUT-1:0] o_rstn,
    output logic             o_done
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
    ,
    output logic [7:0]       o_rst_cnt
`endif
);

    localparam int            CW        = cntWidth(HOLD_CYC, GAP_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

    logic [N_SRC-1:0] srcSync;
    logic             reqActive;
    rstState_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [N_OUT-1:0] rstn_q;
    logic             done_q;
    logic [N_OUT-1:0] rstn_d;

    for (genvar g = 0; g < N_SRC; g++) begin : gSync
        ipsxe_fft_rst_sync_cell #(
            .STAGES (SYNC_STAGES)
        ) uSync (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_arstn (i_arstn_src[g]),
            .o_sync  (srcSync[g])
        );
    end

    assign reqActive = ~&srcSync;

    // Outputs form a thermometer code, so the next release is just a shift-in of one more bit.
    always_comb begin
        rstn_d    = rstn_q;
        rstn_d[0] = 1'b1;
        for (int k = 1; k < N_OUT; k++) begin
            rstn_d[k] = rstn_q[k-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || reqActive) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= '0;
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        if (GAP_CYC == 0 || N_OUT == 1) begin
                            rstn_q  <= '1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rstn_q  <= rstn_d;
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q  <= '0;
                        rstn_q <= rstn_d;
                        if (&rstn_d) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
            endcase
        end
    end

    assign o_rstn = rstn_q;
    assign o_done = done_q;

`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
    logic [7:0] rstCnt_q;

    // Counts fresh re-entries into reset from any later state; saturates instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rstCnt_q <= '0;
        end else if (reqActive && state_q != ST_ASSERT && rstCnt_q != 8'hFF) begin
            rstCnt_q <= rstCnt_q + 8'd1;
        end
    end

    assign o_rst_cnt = rstCnt_q;
`endif

endmodule

// File: tb/tb_ipsxe_fft_rst_seq.sv
// Bench for ipsxe_fft_rst_seq: fixed vector table, hand sequences for the corner cases, and a
// randomized run against a model that derives outputs from the time since the last disturbance.
module tb_ipsxe_fft_rst_seq;

    localparam int NS  = 2;
    localparam int S   = 2;
    localparam int H   = 16;
    localparam int NO  = 4;
    localparam int G   = 4;
    localparam int S2  = 3;
    localparam int H2  = 3;
    localparam int NO2 = 8;
    localparam int G2  = 0;
    localparam int NVEC = 11;

    typedef struct {
        int            relEdge;
        logic [NO-1:0]  rstn;
        logic          done;
        logic [NO2-1:0] rstn2;
        logic          done2;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NS-1:0]  src;
    logic [0:0]     src2;
    logic [NO-1:0]  rstn;
    logic           done;
    logic [NO2-1:0] rstn2;
    logic           done2;
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
    logic [7:0]     rstCnt;
    logic [7:0]     rstCnt2;
`endif

    int nChecks;
    int nFail;
    int edgeNo;
    int base;
    int lastDist;
    int lastDist2;
    bit pend;
    bit pend2;
    int cntExp;
    logic [NO-1:0]  rstnExp;
    logic           doneExp;
    logic [NO2-1:0] rstn2Exp;
    logic           done2Exp;
    vec_t vecs[NVEC];

    always #5 clk = ~clk;

    ipsxe_fft_rst_seq #(
        .N_SRC(NS), .SYNC_STAGES(S), .HOLD_CYC(H), .N_OUT(NO), .GAP_CYC(G)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_arstn_src (src),
        .o_rstn      (rstn),
        .o_done      (done)
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        ,
        .o_rst_cnt   (rstCnt)
`endif
    );

    ipsxe_fft_rst_seq #(
        .N_SRC(1), .SYNC_STAGES(S2), .HOLD_CYC(H2), .N_OUT(NO2), .GAP_CYC(G2)
    ) dut2 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_arstn_src (src2),
        .o_rstn      (rstn2),
        .o_done      (done2)
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        ,
        .o_rst_cnt   (rstCnt2)
`endif
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at edge %0d: actual=%0h required=%0h", name, edgeNo, act, exp);
        end
    endtask

    // Output k is free once enough edges have passed since the last disturbance (reset or
    // a sampled low source); a low source only takes effect one edge later than i_rst.
    task automatic applyStimulus(input logic r, input logic [NS-1:0] s, input logic s2);
        int dPrev;
        rst  = r;
        src  = s;
        src2 = s2;
        @(posedge clk);
        edgeNo++;
        dPrev = edgeNo - 1 - lastDist;
        if (r) cntExp = 0;
        else if (pend && dPrev >= S + 1 && cntExp < 255) cntExp++;
        if (pend)  lastDist  = edgeNo - 1;
        if (pend2) lastDist2 = edgeNo - 1;
        if (r) begin
            lastDist  = edgeNo;
            lastDist2 = edgeNo;
        end
        pend  = !r && (s != '1);
        pend2 = !r && !s2;
        for (int k = 0; k < NO; k++)  rstnExp[k]  = ((edgeNo - lastDist)  >= (S + H + 2 + k * G));
        for (int k = 0; k < NO2; k++) rstn2Exp[k] = ((edgeNo - lastDist2) >= (S2 + H2 + 2 + k * G2));
        doneExp  = rstnExp[NO-1];
        done2Exp = rstn2Exp[NO2-1];
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_rstn"},  32'(rstn),  32'(rstnExp));
        checkVal({tag, "_done"},  32'(done),  32'(doneExp));
        checkVal({tag, "_rstn2"}, 32'(rstn2), 32'(rstn2Exp));
        checkVal({tag, "_done2"}, 32'(done2), 32'(done2Exp));
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        checkVal({tag, "_cnt"},   32'(rstCnt), 32'(cntExp));
`endif
    endtask

    initial begin
        nChecks = 0; nFail = 0; edgeNo = 0; base = 0;
        lastDist = 0; lastDist2 = 0; pend = 0; pend2 = 0; cntExp = 0;
        rst = 1'b1; src = '1; src2 = 1'b1;

        vecs[0]  = '{6,  4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{7,  4'b0000, 1'b0, 8'hFF, 1'b1};
        vecs[2]  = '{18, 4'b0000, 1'b0, 8'hFF, 1'b1};
        vecs[3]  = '{19, 4'b0001, 1'b0, 8'hFF, 1'b1};
        vecs[4]  = '{22, 4'b0001, 1'b0, 8'hFF, 1'b1};
        vecs[5]  = '{23, 4'b0011, 1'b0, 8'hFF, 1'b1};
        vecs[6]  = '{26, 4'b0011, 1'b0, 8'hFF, 1'b1};
        vecs[7]  = '{27, 4'b0111, 1'b0, 8'hFF, 1'b1};
        vecs[8]  = '{30, 4'b0111, 1'b0, 8'hFF, 1'b1};
        vecs[9]  = '{31, 4'b1111, 1'b1, 8'hFF, 1'b1};
        vecs[10] = '{35, 4'b1111, 1'b1, 8'hFF, 1'b1};

        $display("[TB] reset phase");
        repeat (3) begin
            applyStimulus(1'b1, '1, 1'b1);
            checkOutput("reset");
        end
        checkVal("reset_rstn_const", 32'(rstn), 32'd0);
        checkVal("reset_done_const", 32'(done), 32'd0);

        $display("[TB] nominal release sequence");
        base = edgeNo + 1;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(1'b0, '1, 1'b1);
            checkOutput("nominal");
            for (int v = 0; v < NVEC; v++) begin
                if (vecs[v].relEdge == edgeNo - base) begin
                    checkVal("vec_rstn",  32'(rstn),  32'(vecs[v].rstn));
                    checkVal("vec_done",  32'(done),  32'(vecs[v].done));
                    checkVal("vec_rstn2", 32'(rstn2), 32'(vecs[v].rstn2));
                    checkVal("vec_done2", 32'(done2), 32'(vecs[v].done2));
                end
            end
        end

        $display("[TB] glitch during hold");
        applyStimulus(1'b1, '1, 1'b1);
        checkOutput("reset2");
        base = edgeNo + 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, (i == 13) ? 2'b01 : 2'b11, 1'b1);
            checkOutput("glitch");
            if (i == 32) checkVal("glitch_rstn_held", 32'(rstn), 32'd0);
            if (i == 33) checkVal("glitch_rstn0_rise", 32'(rstn), 32'd1);
        end

        $display("[TB] source drop after partial release");
        applyStimulus(1'b0, 2'b10, 1'b1);
        checkOutput("drop");
        checkVal("drop_same_edge_rstn", 32'(rstn), 32'h3);
        applyStimulus(1'b0, '1, 1'b1);
        checkOutput("drop_next");
        checkVal("drop_rstn", 32'(rstn), 32'd0);
        checkVal("drop_done", 32'(done), 32'd0);
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        checkVal("drop_cnt", 32'(rstCnt), 32'd2);
`endif

        $display("[TB] reset pulse during release");
        while (edgeNo - base < 62) begin
            applyStimulus(1'b0, '1, 1'b1);
            checkOutput("prerst");
        end
        checkVal("prerst_rstn", 32'(rstn), 32'd1);
        applyStimulus(1'b1, '1, 1'b1);
        checkOutput("midrst");
        checkVal("midrst_rstn", 32'(rstn), 32'd0);
        checkVal("midrst_done", 32'(done), 32'd0);
`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        checkVal("midrst_cnt", 32'(rstCnt), 32'd0);
`endif
        base = edgeNo + 1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus(1'b0, '1, 1'b1);
            checkOutput("restart");
            if (i == S + H)     checkVal("restart_rstn_held", 32'(rstn), 32'd0);
            if (i == S + H + 1) checkVal("restart_rstn0_rise", 32'(rstn), 32'd1);
        end

        $display("[TB] randomized run");
        for (int i = 0; i < 3000; i++) begin
            logic          r;
            logic [NS-1:0] s;
            logic          s2;
            r = ($urandom_range(0, 399) == 0);
            for (int b = 0; b < NS; b++) s[b] = ($urandom_range(0, 79) != 0);
            s2 = ($urandom_range(0, 29) != 0);
            applyStimulus(r, s, s2);
            checkOutput("random");
        end

`ifdef IPSXE_FFT_RST_SEQ_CNT_EN
        $display("[TB] counter saturation");
        applyStimulus(1'b1, '1, 1'b1);
        checkOutput("sat_reset");
        for (int p = 0; p < 300; p++) begin
            applyStimulus(1'b0, 2'b10, 1'b1);
            checkOutput("sat");
            repeat (34) begin
                applyStimulus(1'b0, '1, 1'b1);
                checkOutput("sat");
            end
        end
        checkVal("sat_final", 32'(rstCnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
